// File: rtl/xpi_arb_pkg.sv
// xpi_arb_pkg: shared state encoding, owner codes and parked pin levels for the XPI bus arbiter.
package xpi_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN_X, OWN_C, GAP} state_t;
  localparam logic OWNER_X = 1'b0;
  localparam logic OWNER_C = 1'b1;
  localparam logic PARK_CS = 1'b1;
  localparam logic PARK_CLK = 1'b0;
endpackage

// File: rtl/xpi_gap_timer.sv
// xpi_gap_timer: loadable down-counter timing the forced CS-high gap; done when it reaches zero.
module xpi_gap_timer #(
  parameter int CS_GAP = 4
) (
  input  logic clk,
  input  logic load,
  output logic done
);
  localparam int W = $clog2(CS_GAP + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= load ? W'(CS_GAP - 1) : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign done = cnt == '0;
endmodule

// File: rtl/xpi_bus_arbiter.sv
// xpi_bus_arbiter: grants whole CS-low transactions on the quad-SPI pins to X (fetch) or C (command).
// Optional starvation guard for C is enabled by defining XPI_ARB_STARVE_EN.
module xpi_bus_arbiter
  import xpi_arb_pkg::*;
#(
  parameter int CS_GAP = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       x_req,
  output logic       x_gnt,
  input  logic [3:0] x_XPIo,
  input  logic [3:0] x_XPIdir,
  input  logic       x_XPICS,
  input  logic       x_XPICLK,
  output logic [3:0] x_XPIi,
  input  logic       c_req,
  output logic       c_gnt,
  input  logic [3:0] c_XPIo,
  input  logic [3:0] c_XPIdir,
  input  logic       c_XPICS,
  input  logic       c_XPICLK,
  output logic [3:0] c_XPIi,
  output logic [3:0] XPIo,
  output logic [3:0] XPIdir,
  output logic       XPICS,
  output logic       XPICLK,
  input  logic [3:0] XPIi,
  output logic       owner,
  output logic       busy
);
  state_t state;
  logic x_end, c_end, follow_x, follow_c, load, gap_done, c_win;
  assign x_end = !x_req && x_XPICS;
  assign c_end = !c_req && c_XPICS;
  assign follow_x = state == OWN_X && !x_end;
  assign follow_c = state == OWN_C && !c_end;
  assign load = HRESET || (state == OWN_X && x_end) || (state == OWN_C && c_end);
  xpi_gap_timer #(.CS_GAP(CS_GAP)) u_gap (
    .clk (HCLK),
    .load(load),
    .done(gap_done)
  );
`ifdef XPI_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  assign c_win = c_req && (!x_req || starve_cnt == SW'(STARVE_MAX));
  always_ff @(posedge HCLK)
    if (HRESET || (state == IDLE && (c_win || !c_req))) starve_cnt <= '0;
    else if (state == IDLE && x_req) starve_cnt <= starve_cnt + 1'b1;
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign c_win = c_req && !x_req;
`endif
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= GAP;
      owner <= OWNER_X;
    end else begin
      case (state)
        IDLE: if (c_win) begin
          state <= OWN_C;
          owner <= OWNER_C;
        end else if (x_req) begin
          state <= OWN_X;
          owner <= OWNER_X;
        end
        OWN_X: if (x_end) state <= GAP;
        OWN_C: if (c_end) state <= GAP;
        default: if (gap_done) state <= IDLE;
      endcase
    end
  end
  // Pins park on the ending edge too, so GAP always presents a clean deselect.
  always_ff @(posedge HCLK) begin
    if (HRESET || !(follow_x || follow_c)) {XPIo, XPIdir, XPICS, XPICLK} <= {4'h0, 4'h0, PARK_CS, PARK_CLK};
    else if (follow_x) {XPIo, XPIdir, XPICS, XPICLK} <= {x_XPIo, x_XPIdir, x_XPICS, x_XPICLK};
    else {XPIo, XPIdir, XPICS, XPICLK} <= {c_XPIo, c_XPIdir, c_XPICS, c_XPICLK};
  end
  assign x_gnt = state == OWN_X;
  assign c_gnt = state == OWN_C;
  assign busy = state != IDLE;
  assign x_XPIi = x_gnt ? XPIi : 4'h0;
  assign c_XPIi = c_gnt ? XPIi : 4'h0;
endmodule

// File: tb/tb_xpi_bus_arbiter.sv
// tb_xpi_bus_arbiter: scoreboard bench; a transaction-level model predicts every cycle's outputs.
module tb_xpi_bus_arbiter;
  localparam int CS_GAP = 4;
  localparam int STARVE_MAX = 8;
`ifdef XPI_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  logic HCLK = 1'b0;
  logic HRESET;
  logic x_req, x_gnt, x_XPICS, x_XPICLK, c_req, c_gnt, c_XPICS, c_XPICLK;
  logic [3:0] x_XPIo, x_XPIdir, x_XPIi, c_XPIo, c_XPIdir, c_XPIi;
  logic [3:0] XPIo, XPIdir, XPIi;
  logic XPICS, XPICLK, owner, busy;
  always #5 HCLK = ~HCLK;
  xpi_bus_arbiter #(.CS_GAP(CS_GAP), .STARVE_MAX(STARVE_MAX)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .x_req(x_req), .x_gnt(x_gnt), .x_XPIo(x_XPIo), .x_XPIdir(x_XPIdir),
    .x_XPICS(x_XPICS), .x_XPICLK(x_XPICLK), .x_XPIi(x_XPIi),
    .c_req(c_req), .c_gnt(c_gnt), .c_XPIo(c_XPIo), .c_XPIdir(c_XPIdir),
    .c_XPICS(c_XPICS), .c_XPICLK(c_XPICLK), .c_XPIi(c_XPIi),
    .XPIo(XPIo), .XPIdir(XPIdir), .XPICS(XPICS), .XPICLK(XPICLK), .XPIi(XPIi),
    .owner(owner), .busy(busy)
  );
  typedef struct packed {
    logic xg, cg, own, bsy, cs, sck;
    logic [3:0] o, dir;
  } snap_t;
  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  // Model: who holds the bus (-1 none, 0 X, 1 C), remaining deselect cycles, C's wait tally.
  int m_own = -1;
  int m_gap = 0;
  int m_starve = 0;
  logic m_last = 1'b0;
  logic m_cs = 1'b1, m_sck = 1'b0;
  logic [3:0] m_o = 4'h0, m_dir = 4'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void park();
    {m_cs, m_sck, m_o, m_dir} = {1'b1, 1'b0, 4'h0, 4'h0};
  endfunction
  task automatic model_step();
    logic xe, ce, cw;
    xe = !x_req && x_XPICS;
    ce = !c_req && c_XPICS;
    if (HRESET) begin
      m_own = -1; m_gap = CS_GAP; m_last = 1'b0; m_starve = 0; park();
    end else if (m_own == 0) begin
      if (xe) begin m_own = -1; m_gap = CS_GAP; park(); end
      else {m_cs, m_sck, m_o, m_dir} = {x_XPICS, x_XPICLK, x_XPIo, x_XPIdir};
    end else if (m_own == 1) begin
      if (ce) begin m_own = -1; m_gap = CS_GAP; park(); end
      else {m_cs, m_sck, m_o, m_dir} = {c_XPICS, c_XPICLK, c_XPIo, c_XPIdir};
    end else if (m_gap > 0) begin
      m_gap--; park();
    end else begin
      park();
      cw = c_req && (!x_req || (STARVE_EN && m_starve == STARVE_MAX));
      if (cw) begin m_own = 1; m_last = 1'b1; m_starve = 0; end
      else if (x_req) begin m_own = 0; m_last = 1'b0; if (c_req) m_starve++; end
      if (!c_req) m_starve = 0;
    end
    exp_q.push_back('{xg: m_own == 0, cg: m_own == 1, own: m_last, bsy: m_own >= 0 || m_gap > 0,
                      cs: m_cs, sck: m_sck, o: m_o, dir: m_dir});
  endtask
  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask
  always @(negedge HCLK) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs", {x_gnt, c_gnt, owner, busy, XPICS, XPICLK, XPIo, XPIdir}, e);
      chk("xpii_route", {x_XPIi, c_XPIi}, {e.xg ? XPIi : 4'h0, e.cg ? XPIi : 4'h0});
    end
  end
  initial begin
    int n, xcount;
    HRESET = 1'b1; x_req = 1'b1; c_req = 1'b0;
    {x_XPICS, x_XPICLK, x_XPIo, x_XPIdir} = {1'b1, 1'b0, 4'h0, 4'h0};
    {c_XPICS, c_XPICLK, c_XPIo, c_XPIdir} = {1'b1, 1'b0, 4'h0, 4'h0};
    XPIi = 4'h5;
    repeat (3) tick();
    chk("rst_cs", XPICS, 1); chk("rst_sck", XPICLK, 0); chk("rst_dir", XPIdir, 0); chk("rst_xgnt", x_gnt, 0);
    HRESET = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!x_gnt && n < 20);
    chk("rst_to_xgnt", n, CS_GAP + 1);
    x_XPICS = 1'b0; x_XPIo = 4'hA;
    tick();
    chk("x_pin_cs", XPICS, 0); chk("x_pin_o", XPIo, 4'hA);
    x_XPICS = 1'b1;
    tick();
    x_req = 1'b0;
    tick();
    chk("x_end_gnt", x_gnt, 0);
    n = 1;
    while (busy && n < 20) begin tick(); n++; end
    chk("gap_to_idle", n, CS_GAP + 1);
    x_req = 1'b1; c_req = 1'b1;
    tick();
    chk("both_x_wins", {x_gnt, c_gnt}, 2'b10); chk("c_xpii_blocked", c_XPIi, 0);
    tick();
    x_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!c_gnt && n < 20);
    chk("c_after_x", n, CS_GAP + 2);
    c_XPICS = 1'b0;
    tick();
    c_req = 1'b0;
    repeat (3) begin
      tick();
      chk("early_drop_gnt", c_gnt, 1); chk("early_drop_cs", XPICS, 0);
    end
    c_XPICS = 1'b1;
    tick();
    chk("c_end_gnt", c_gnt, 0); chk("c_end_busy", busy, 1);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("idle_before_starve", busy, 0);
    c_req = 1'b1; x_req = 1'b1; xcount = 0; n = 0;
    while (!c_gnt && n < 300) begin
      tick(); n++;
      if (x_gnt) begin
        xcount++;
        x_req = 1'b0;
        tick(); n++;
        x_req = xcount < 9;
      end
    end
    chk("x_before_c", xcount, STARVE_EN ? 8 : 9);
    chk("c_granted", c_gnt, 1);
    x_req = 1'b0; c_XPICS = 1'b0;
    repeat (2) tick();
    HRESET = 1'b1;
    tick();
    chk("midrst_cs", XPICS, 1); chk("midrst_cgnt", c_gnt, 0);
    HRESET = 1'b0; c_XPICS = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!c_gnt && n < 20);
    chk("midrst_to_cgnt", n, CS_GAP + 1);
    repeat (3000) begin
      tick();
      HRESET = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 7) == 0) x_req = !x_req;
      if ($urandom_range(0, 7) == 0) c_req = !c_req;
      if ($urandom_range(0, 3) == 0) x_XPICS = !x_XPICS;
      if ($urandom_range(0, 3) == 0) c_XPICS = !c_XPICS;
      x_XPICLK = 1'($urandom); c_XPICLK = 1'($urandom);
      x_XPIo = 4'($urandom); x_XPIdir = 4'($urandom);
      c_XPIo = 4'($urandom); c_XPIdir = 4'($urandom);
      XPIi = 4'($urandom);
    end
    #20;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
